// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // A byte address is unusable when misaligned or when its word index is past the array.
    // The full 32-bit address is compared so high addresses never alias onto low words.
    function automatic logic addr_bad(input logic [XLEN-1:0] addr, input int unsigned depth);
        logic [XLEN-1:0] word_s;
        word_s = {2'b00, addr[XLEN-1:2]};
        return (addr[1:0] != 2'b00) || (word_s >= depth);
    endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Instruction storage: one write port, one registered read port with read-old-data.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_idx,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem_r [DEPTH];
    logic [XLEN-1:0] rd_data_r;

    // Program-load write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Registered read; a same-edge write lands after this sample, so old data is returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {XLEN{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with flush, backpressure and a program-load port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] rsp_addr,
    output logic            rsp_err,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((LATENCY > 32'd1) ? (LATENCY - 32'd2) : 32'd0);

    state_e          state_r;
    state_e          state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [XLEN-1:0] addr_r;
    logic            rsp_valid_r;
    logic [XLEN-1:0] rsp_addr_r;
    logic            rsp_err_r;
    logic            req_ready_s;
    logic            accept_s;
    logic            enter_resp_s;
    logic [XLEN-1:0] src_addr_s;
    logic            src_bad_s;
    logic            rd_en_s;
    logic            wr_ok_s;
    logic [XLEN-1:0] arr_rd_data_s;

    assign req_ready_s = (state_r == ST_IDLE) && !flush && !reset;
    assign accept_s    = req_valid && req_ready_s;
    // With single-cycle latency the response is formed from the address being accepted.
    assign src_addr_s  = (state_r == ST_IDLE) ? req_addr : addr_r;
    assign src_bad_s   = addr_bad(src_addr_s, DEPTH);
    assign rd_en_s     = enter_resp_s && !src_bad_s && !reset;
    assign wr_ok_s     = wr_en && !addr_bad(wr_addr, DEPTH);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok_s),
        .wr_idx  (wr_addr[AW+1:2]),
        .wr_data (wr_data),
        .rd_en   (rd_en_s),
        .rd_idx  (src_addr_s[AW+1:2]),
        .rd_data (arr_rd_data_s)
    );

    // Next-state and countdown; flush beats every other transition.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_resp_s = 1'b0;
        if (flush) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (LATENCY == 32'd1) begin
                            state_s      = ST_RESP;
                            enter_resp_s = 1'b1;
                        end else begin
                            state_s = ST_WAIT;
                            cnt_s   = WAIT_INIT;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, latched request and response registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            addr_r      <= {XLEN{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_addr_r  <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rsp_valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                addr_r <= req_addr;
            end
            if (enter_resp_s) begin
                rsp_addr_r <= src_addr_s;
                rsp_err_r  <= src_bad_s;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_addr  = rsp_addr_r;
    assign rsp_err   = rsp_err_r;
    // Erroring fetches never read the array; the NOP is substituted from the held error flag.
    assign rsp_data  = rsp_err_r ? NOP_INSN : arr_rd_data_s;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed checks of imem_responder against a cycle-level behavioural model.
module tb_imem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush, wr_en;
    logic [31:0] req_addr, rsp_data, rsp_addr, wr_addr, wr_data;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int checks = 0;
    int errors = 0;

    // model: phase 0 = idle, 1 = waiting m_left more edges, 2 = holding a response
    logic [31:0] m_mem [DEPTH];
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_req_addr, m_addr, m_data;
    logic        m_err;
    bit          m_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    task automatic produce(input logic [31:0] a);
        m_addr  = a;
        m_err   = bad(a);
        m_data  = m_err ? 32'h0000_0013 : m_mem[int'(a >> 2)];
        m_phase = 2;
    endtask

    // One clock: compare DUT against the model, advance the model with this cycle's inputs, clock.
    task automatic step();
        #1;
        if (m_init) begin
            chk("req_ready", 32'(req_ready), 32'((m_phase == 0) && !flush && !reset));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_addr", rsp_addr, m_addr);
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        if (reset) begin
            m_phase = 0; m_data = 32'h0; m_addr = 32'h0; m_err = 1'b0; m_init = 1'b1;
        end else if (m_init) begin
            if (flush) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (req_valid) begin
                    // the acceptance edge is the first of LAT edges before the response shows
                    if (LAT == 1) produce(req_addr);
                    else begin m_phase = 1; m_left = LAT - 1; m_req_addr = req_addr; end
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) produce(m_req_addr);
            end else if (rsp_ready) begin
                m_phase = 0;
            end
        end
        if (wr_en && !bad(wr_addr)) m_mem[int'(wr_addr >> 2)] = wr_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic req(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] a,
                               input logic [31:0] d, input logic e);
        rsp_ready = 1'b0;
        req(a);
        chk({name, "_early"}, 32'(rsp_valid), 32'd0);
        step();
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_data"}, rsp_data, d);
        chk({name, "_addr"}, rsp_addr, a);
        chk({name, "_err"}, 32'(rsp_err), 32'(e));
        rsp_ready = 1'b1;
        step();
        chk({name, "_done"}, 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        logic [31:0] idx;
        r   = $urandom_range(0, 9);
        idx = 32'($urandom_range(0, DEPTH - 1));
        if (r < 7)       return idx << 2;
        else if (r == 7) return (idx << 2) | 32'($urandom_range(1, 3));
        else if (r == 8) return (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2;
        else             return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        flush = 1'b0; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_addr", rsp_addr, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) write(32'(i) << 2, $urandom);

        // basic fetch, misaligned and out-of-range fetches
        write(32'h0000_000C, 32'hDEAD_BEEF);
        fetch_check("fetch_0c", 32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
        fetch_check("fetch_0e", 32'h0000_000E, 32'h0000_0013, 1'b1);
        fetch_check("fetch_400", 32'h0000_0400, 32'h0000_0013, 1'b1);

        // backpressure: response held for five cycles
        req(32'h0000_000C);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, 32'hDEAD_BEEF);
            chk("hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("hold_release_valid", 32'(rsp_valid), 32'd0);
        chk("hold_release_ready", 32'(req_ready), 32'd1);

        // flush in WAIT discards the request; the next one is served normally
        write(32'h0000_0010, 32'hCAFE_F00D);
        req(32'h0000_000C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_no_valid", 32'(rsp_valid), 32'd0);
        fetch_check("after_flush", 32'h0000_0010, 32'hCAFE_F00D, 1'b0);

        // write on the read edge returns old data; a later fetch sees the new word
        write(32'h0000_0014, 32'h1111_1111);
        req(32'h0000_0014);
        wr_en = 1'b1; wr_addr = 32'h0000_0014; wr_data = 32'h2222_2222;
        step();
        wr_en = 1'b0;
        chk("row_valid", 32'(rsp_valid), 32'd1);
        chk("row_old_data", rsp_data, 32'h1111_1111);
        rsp_ready = 1'b1;
        step();
        fetch_check("row_new", 32'h0000_0014, 32'h2222_2222, 1'b0);

        // reset during WAIT loses the request but keeps memory
        req(32'h0000_000C);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_ready", 32'(req_ready), 32'd1);
        fetch_check("retained", 32'h0000_000C, 32'hDEAD_BEEF, 1'b0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = rnd_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = rnd_addr();
            wr_data   = $urandom;
            step();
        end
        req_valid = 1'b0; flush = 1'b0; reset = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit instruction words in the array (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to rsp_valid (legal range 1..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: the reset; it is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a fetch request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port req_addr, input, 32 bits: the byte address of the fetch, driven from the program counter.
REQ-008 SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-009 SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-010 SHALL have port rsp_data, output, 32 bits: the instruction word.
REQ-011 SHALL have port rsp_addr, output, 32 bits: the byte address this response belongs to.
REQ-012 SHALL have port rsp_err, output, 1 bit: the address was misaligned or out of range.
REQ-013 SHALL have port flush, input, 1 bit: a branch or jump redirect; it discards in-flight work.
REQ-014 SHALL have port wr_en, input, 1 bit; port wr_addr, input, 32 bits (byte address); and port wr_data, input, 32 bits. Together these form the program-load write port.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL equal !flush; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1; accepting it latches req_addr.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with counter=LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when the counter is 0, the FSM SHALL go to RESP on the next edge.
REQ-020 The effect of REQ-018 and REQ-019 is that rsp_valid rises exactly LATENCY edges after the acceptance edge.
REQ-021 The array SHALL be read on the edge that enters RESP.
REQ-022 A write in that same cycle SHALL NOT affect the read (read-old-data).
REQ-023 rsp_data, rsp_addr and rsp_err SHALL be registered.
REQ-024 These registered outputs SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-025 In RESP, when rsp_ready=1, the FSM SHALL go to IDLE next edge. There is no same-cycle back-to-back acceptance, so the maximum throughput is one response per LATENCY+1 cycles.
REQ-026 rsp_err SHALL be 1 when req_addr[1:0] is not 0, or when req_addr[31:2] is DEPTH or greater.
REQ-027 When rsp_err=1, rsp_data SHALL be 32'h0000_0013 (NOP) and the array SHALL NOT be read.
REQ-028 The word index SHALL be addr[log2(DEPTH)+1:2], and range checking SHALL use the full 32-bit address (no wrap-around).
REQ-029 flush=1 in any state SHALL force IDLE on the next edge and clear rsp_valid. Any pending response is discarded.
REQ-030 flush SHALL have priority over acceptance, countdown and rsp_ready.
REQ-031 When wr_en=1, mem[wr_addr index] SHALL be written with wr_data, in any state.
REQ-032 Misaligned or out-of-range writes SHALL be ignored.
REQ-033 Writes SHALL NOT affect the FSM.

Reset
REQ-034 When reset=1 at an edge, the FSM SHALL go to IDLE and the counter SHALL be 0.
REQ-035 On reset, rsp_valid, rsp_err, rsp_data and rsp_addr SHALL be 0.
REQ-036 Reset SHALL have priority over flush and over any in-flight request; that request is lost.
REQ-037 Reset SHALL NOT clear the array contents.
REQ-038 During reset, req_ready SHALL be 0.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the NOP constant 32'h0000_0013, and the XLEN=32 constant.
REQ-040 The storage SHALL be a single sub-module, imem_array: a 1-write, 1-read synchronous RAM with read-old-data behaviour.

Verification
REQ-041 Load mem[3]=32'hDEADBEEF, then request 0x0C with LATENCY=2 -> rsp_valid rises 2 edges after acceptance with rsp_data=32'hDEADBEEF, rsp_addr=0x0C and rsp_err=0.
REQ-042 Request 0x0E -> rsp_err=1 and rsp_data=32'h00000013. With DEPTH=256, request 0x400 -> rsp_err=1.
REQ-043 Hold rsp_ready=0 for 5 cycles while RESP is active -> rsp_valid and rsp_data stay constant and req_ready stays 0; raising rsp_ready -> IDLE on the next edge.
REQ-044 Assert flush in WAIT (one cycle after acceptance) -> no rsp_valid for that request; a new request on the following cycle is served normally.
REQ-045 Write mem[5]=32'h11111111, then request 0x14 and write mem[5]=32'h22222222 in the cycle that enters RESP -> rsp_data=32'h11111111; a second fetch of 0x14 returns 32'h22222222.
REQ-046 Assert reset during WAIT -> the next cycle has rsp_valid=0, req_ready=1, and the array contents are retained.
